// File: rtl/isa_pkg.sv
// ISA constants and ID-stage state encoding shared by the decode stage.
package isa_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_HAZ   = 2'd2
  } id_state_e;

  // rt is read (not written) by R-type, branches and stores.
  function automatic logic rt_is_source(input logic [5:0] opcode);
    logic src;
    case (opcode)
      OP_RTYPE, OP_BEQ, OP_BNE, OP_SW: src = 1'b1;
      default:                         src = 1'b0;
    endcase
    return src;
  endfunction

endpackage

// File: rtl/decode.sv
// Field splitter: extracts opcode, rs and rt from a 32-bit instruction word.
module decode (
  input  logic [31:0] insn_i,
  output logic [5:0]  opcode_o,
  output logic [4:0]  rs_o,
  output logic [4:0]  rt_o
);

  logic unused_low;

  assign opcode_o   = insn_i[31:26];
  assign rs_o       = insn_i[25:21];
  assign rt_o       = insn_i[20:16];
  assign unused_low = ^insn_i[15:0];

endmodule

// File: rtl/decode_issue_ctrl.sv
// ID stage controller: IF/ID register, valid/ready issue to EX, load-use stall, flush.
//   state    | meaning
//   ST_EMPTY | no instruction held
//   ST_FULL  | instruction held, no hazard
//   ST_HAZ   | instruction held, load-use hazard active
module decode_issue_ctrl
  import isa_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              if_valid,
  input  logic [DATA_W-1:0] if_insn,
  input  logic [DATA_W-1:0] if_pc,
  output logic              if_ready,
  input  logic              flush,
  input  logic              ex_ready,
  input  logic              ex_is_load,
  input  logic [4:0]        ex_rt,
  output logic              id_valid,
  output logic [DATA_W-1:0] id_insn,
  output logic [DATA_W-1:0] id_pc,
  output logic [CNT_W-1:0]  stall_cnt
);

  id_state_e         state_q, state_d;
  logic [DATA_W-1:0] insn_q, insn_d;
  logic [DATA_W-1:0] pc_q, pc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [5:0] opcode;
  logic [4:0] rs;
  logic [4:0] rt;
  logic       held;
  logic       hazard;
  logic       id_fire;
  logic       if_fire;

  decode u_decode (
    .insn_i   (insn_q[31:0]),
    .opcode_o (opcode),
    .rs_o     (rs),
    .rt_o     (rt)
  );

  assign held = (state_q != ST_EMPTY);

  // A load into $0 never produces a value worth waiting for.
  assign hazard = held && ex_is_load && (ex_rt != 5'd0) &&
                  ((rs == ex_rt) || (rt_is_source(opcode) && (rt == ex_rt)));

  always_comb begin
    state_d  = state_q;
    insn_d   = insn_q;
    pc_d     = pc_q;
    cnt_d    = cnt_q;
    id_valid = held && !hazard && !flush;
    id_fire  = id_valid && ex_ready;
    if_ready = flush || !held || id_fire;
    if_fire  = if_valid && if_ready;

    if (flush) begin
      // Wrong-path beat accepted this cycle is dropped on the floor.
      state_d = ST_EMPTY;
    end else begin
      if (if_fire) begin
        insn_d = if_insn;
        pc_d   = if_pc;
      end
      case (state_q)
        ST_EMPTY: begin
          if (if_fire) state_d = ST_FULL;
        end
        ST_FULL, ST_HAZ: begin
          if (id_fire) state_d = if_fire ? ST_FULL : ST_EMPTY;
          else         state_d = hazard ? ST_HAZ : ST_FULL;
        end
        default: state_d = ST_EMPTY;
      endcase
      if (hazard && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= ST_EMPTY;
      insn_q  <= '0;
      pc_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      insn_q  <= insn_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign id_insn   = insn_q;
  assign id_pc     = pc_q;
  assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_decode_issue_ctrl.sv
// Scoreboard bench for decode_issue_ctrl: directed beats, monitor checks every EX transfer.
module tb_decode_issue_ctrl;

  logic        clock = 1'b0;
  logic        reset_n, if_valid, flush, ex_ready, ex_is_load;
  logic [31:0] if_insn, if_pc;
  logic [4:0]  ex_rt;

  logic        if_ready, id_valid;
  logic [31:0] id_insn, id_pc;
  logic [15:0] stall_cnt;

  logic        s_if_ready, s_id_valid;
  logic [31:0] s_id_insn, s_id_pc;
  logic [1:0]  s_stall_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] insn;
    logic [31:0] pc;
  } beat_t;

  beat_t exp_q[$];
  beat_t mon_e;

  always #5 clock = ~clock;

  decode_issue_ctrl #(.DATA_W(32), .CNT_W(16)) u_dut (
    .clock(clock), .reset_n(reset_n), .if_valid(if_valid), .if_insn(if_insn),
    .if_pc(if_pc), .if_ready(if_ready), .flush(flush), .ex_ready(ex_ready),
    .ex_is_load(ex_is_load), .ex_rt(ex_rt), .id_valid(id_valid),
    .id_insn(id_insn), .id_pc(id_pc), .stall_cnt(stall_cnt)
  );

  decode_issue_ctrl #(.DATA_W(32), .CNT_W(2)) u_sat (
    .clock(clock), .reset_n(reset_n), .if_valid(if_valid), .if_insn(if_insn),
    .if_pc(if_pc), .if_ready(s_if_ready), .flush(flush), .ex_ready(ex_ready),
    .ex_is_load(ex_is_load), .ex_rt(ex_rt), .id_valid(s_id_valid),
    .id_insn(s_id_insn), .id_pc(s_id_pc), .stall_cnt(s_stall_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input logic [31:0] insn, input logic [31:0] pc);
    beat_t b;
    b.insn = insn;
    b.pc   = pc;
    exp_q.push_back(b);
  endtask

  // Monitor: every beat EX accepts must be the next expected one.
  always @(negedge clock) begin
    if (reset_n === 1'b1 && id_valid === 1'b1 && ex_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_xfer: got insn 0x%0h pc 0x%0h, required no transfer", id_insn, id_pc);
      end else begin
        mon_e = exp_q.pop_front();
        chk("xfer_insn", id_insn, mon_e.insn);
        chk("xfer_pc", id_pc, mon_e.pc);
      end
    end
  end

  initial begin
    reset_n = 1'b0; if_valid = 1'b0; if_insn = '0; if_pc = '0;
    flush = 1'b0; ex_ready = 1'b1; ex_is_load = 1'b0; ex_rt = '0;
    cyc(); cyc();
    reset_n = 1'b1;
    #1;
    chk("rst_id_valid", {31'd0, id_valid}, 32'd0);
    chk("rst_if_ready", {31'd0, if_ready}, 32'd1);
    chk("rst_id_insn", id_insn, 32'd0);
    chk("rst_id_pc", id_pc, 32'd0);
    chk("rst_stall", {16'd0, stall_cnt}, 32'd0);
    chk("rst_sat_stall", {30'd0, s_stall_cnt}, 32'd0);

    // Back-to-back stream
    if_valid = 1'b1; if_insn = 32'h01284820; if_pc = 32'h0; push(if_insn, if_pc);
    cyc();
    if_insn = 32'h012A5822; if_pc = 32'h4; push(if_insn, if_pc);
    #1;
    chk("t1_valid0", {31'd0, id_valid}, 32'd1);
    chk("t1_insn0", id_insn, 32'h01284820);
    chk("t1_ifready", {31'd0, if_ready}, 32'd1);
    cyc();
    if_valid = 1'b0;
    #1;
    chk("t1_valid1", {31'd0, id_valid}, 32'd1);
    chk("t1_pc1", id_pc, 32'h4);
    cyc();
    #1;
    chk("t1_drained", {31'd0, id_valid}, 32'd0);
    chk("t1_stall", {16'd0, stall_cnt}, 32'd0);

    // Load-use stall
    if_valid = 1'b1; if_insn = 32'h01084820; if_pc = 32'h8; push(if_insn, if_pc);
    cyc();
    if_valid = 1'b0; ex_is_load = 1'b1; ex_rt = 5'd8;
    #1;
    chk("t2_haz_valid", {31'd0, id_valid}, 32'd0);
    chk("t2_haz_ifready", {31'd0, if_ready}, 32'd0);
    cyc();
    ex_is_load = 1'b0;
    #1;
    chk("t2_stall", {16'd0, stall_cnt}, 32'd1);
    chk("t2_sat_stall", {30'd0, s_stall_cnt}, 32'd1);
    chk("t2_release_valid", {31'd0, id_valid}, 32'd1);
    chk("t2_release_insn", id_insn, 32'h01084820);
    cyc();

    // No false stall: rt of lw is a destination; ex_rt of zero never stalls
    ex_is_load = 1'b1; ex_rt = 5'd8;
    if_valid = 1'b1; if_insn = 32'h8D280004; if_pc = 32'hC; push(if_insn, if_pc);
    cyc();
    if_insn = 32'h00004820; if_pc = 32'h10; push(if_insn, if_pc);
    #1;
    chk("t3_lw_valid", {31'd0, id_valid}, 32'd1);
    chk("t3_lw_insn", id_insn, 32'h8D280004);
    chk("t3_lw_stall", {16'd0, stall_cnt}, 32'd1);
    cyc();
    if_valid = 1'b0; ex_rt = 5'd0;
    #1;
    chk("t3_zero_valid", {31'd0, id_valid}, 32'd1);
    chk("t3_zero_insn", id_insn, 32'h00004820);
    chk("t3_zero_stall", {16'd0, stall_cnt}, 32'd1);
    cyc();
    ex_is_load = 1'b0;

    // Flush kills held instruction and the same-cycle fetch beat
    ex_ready = 1'b0;
    if_valid = 1'b1; if_insn = 32'h012A5822; if_pc = 32'h14;
    cyc();
    if_insn = 32'h2108FFFF; if_pc = 32'h18; flush = 1'b1;
    #1;
    chk("t4_flush_valid", {31'd0, id_valid}, 32'd0);
    chk("t4_flush_ifready", {31'd0, if_ready}, 32'd1);
    cyc();
    flush = 1'b0; if_valid = 1'b0; ex_ready = 1'b1;
    #1;
    chk("t4_after_valid", {31'd0, id_valid}, 32'd0);
    chk("t4_after_ifready", {31'd0, if_ready}, 32'd1);
    chk("t4_no_wrongpath", {31'd0, (id_insn == 32'h2108FFFF)}, 32'd0);
    cyc(); cyc();

    // Backpressure: hold three cycles, then transfer exactly once
    ex_ready = 1'b0;
    if_valid = 1'b1; if_insn = 32'h01284820; if_pc = 32'h20; push(if_insn, if_pc);
    cyc();
    if_insn = 32'h012A5822; if_pc = 32'h24; push(if_insn, if_pc);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t5_hold_valid", {31'd0, id_valid}, 32'd1);
      chk("t5_hold_ifready", {31'd0, if_ready}, 32'd0);
      chk("t5_hold_insn", id_insn, 32'h01284820);
      cyc();
    end
    ex_ready = 1'b1;
    #1;
    chk("t5_release_ifready", {31'd0, if_ready}, 32'd1);
    cyc();
    if_valid = 1'b0;
    #1;
    chk("t5_next_insn", id_insn, 32'h012A5822);
    chk("t5_next_valid", {31'd0, id_valid}, 32'd1);
    cyc();
    #1;
    chk("t5_drained", {31'd0, id_valid}, 32'd0);

    // Saturation, flush during hazard, reset mid-hazard
    ex_is_load = 1'b1; ex_rt = 5'd8;
    if_valid = 1'b1; if_insn = 32'h01084820; if_pc = 32'h28;
    cyc();
    if_valid = 1'b0;
    repeat (5) cyc();
    #1;
    chk("t6_sat_stall", {30'd0, s_stall_cnt}, 32'd3);
    chk("t6_wide_stall", {16'd0, stall_cnt}, 32'd6);
    chk("t6_haz_valid", {31'd0, id_valid}, 32'd0);
    chk("t6_haz_ifready", {31'd0, if_ready}, 32'd0);
    flush = 1'b1;
    #1;
    chk("t6_flush_valid", {31'd0, id_valid}, 32'd0);
    chk("t6_flush_ifready", {31'd0, if_ready}, 32'd1);
    cyc();
    flush = 1'b0;
    #1;
    chk("t6_flush_nocount", {16'd0, stall_cnt}, 32'd6);
    chk("t6_flush_empty", {31'd0, id_valid}, 32'd0);
    if_valid = 1'b1; if_insn = 32'h01084820; if_pc = 32'h2C;
    cyc();
    if_valid = 1'b0;
    cyc();
    #1;
    chk("t6_recount", {16'd0, stall_cnt}, 32'd7);
    reset_n = 1'b0; flush = 1'b1;
    cyc();
    #1;
    chk("t6_rst_stall", {16'd0, stall_cnt}, 32'd0);
    chk("t6_rst_sat_stall", {30'd0, s_stall_cnt}, 32'd0);
    chk("t6_rst_valid", {31'd0, id_valid}, 32'd0);
    chk("t6_rst_ifready", {31'd0, if_ready}, 32'd1);
    chk("t6_rst_insn", id_insn, 32'd0);
    reset_n = 1'b1; flush = 1'b0; ex_is_load = 1'b0;
    cyc(); cyc();
    chk("scoreboard_empty", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
